prio_enc_queue: RTL and testbench
=================================

# prio_enc_queue

Parametrised, registered priority encoder with request queueing. Request bits from WIDTH sources are captured into a sticky pending register. One index at a time is handed to a downstream consumer over a valid/ready handshake, and each pending bit is cleared as it is issued. It sits between interrupt/event sources and a single servicing engine. It replaces the purely combinational 8-bit encoder wherever requests are pulses or the consumer can stall.

## Interface
Parameters:
- WIDTH, 8: number of request lines; must be ≥2.
- IDX_W, $clog2(WIDTH): width of the output index; derived, not overridden.
- CNT_W, $clog2(WIDTH+1): width of the pending count; derived.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset, **synchronous, active-high**.
- req, input, WIDTH: request pulses or levels; each set bit is ORed into pending every cycle.
- flush, input, 1: discard all pending requests and any held output.
- out_valid, output, 1: out_idx holds an issued request.
- out_ready, input, 1: consumer accepts out_idx when out_valid && out_ready.
- out_idx, output, IDX_W: index of the issued request.
- pend_cnt, output, CNT_W: popcount of the pending register; combinational from state.

## Operation
- **State:** pending register P[WIDTH-1:0], output register (out_valid, out_idx), and priority pointer ptr[IDX_W-1:0] (round-robin build only).
- **Load:** load = !out_valid || out_ready.
- **Load with P≠0:**
  - sel = winner of P under the active priority rule.
  - out_idx←sel; out_valid←1.
  - P_next = (P & ~onehot(sel)) | req.
- **Load with P=0:** out_valid←0; out_idx holds; P_next = req.
- **No load:** P_next = P | req; out_valid/out_idx hold.
- **Re-request of an issued index:**
  - If req[sel] is asserted in the same cycle sel moves out of P, the bit stays set in P and is issued again later.
  - A request for an index currently held in the output register also re-sets P.
- **Encoding:** requests are never merged or counted beyond one per bit.
- **Fixed priority (default):** highest set index wins; bit WIDTH-1 is highest.
- **flush:**
  - P←0, out_valid←0, out_idx←0.
  - Same-cycle req is dropped.
  - Same-cycle handshake counts as completed.
  - flush overrides everything except rst.
- **rst:** P←0, out_valid←0, out_idx←0, ptr←WIDTH-1; pend_cnt=0.
- **pend_cnt:** excludes the index held in the output register.

## Timing
- req sampled at edge k appears in P after edge k.
- Earliest out_valid rises after edge k+1, so request-to-issue latency is 2 cycles.
- Throughput: one index per cycle while out_ready=1 and P≠0.
- Stall: while out_valid && !out_ready, out_idx is stable and P keeps accumulating.
- An empty-to-valid transition needs no bubble.
- Back-to-back handshakes with a continuously non-empty P give out_valid=1 every cycle.

## Configuration
- **PRIO_ENC_QUEUE_RR_EN defined:** round-robin priority.
  - Search starts at ptr and descends, wrapping from 0 to WIDTH-1.
  - When an index is loaded, ptr←(sel−1) mod WIDTH.
  - ptr resets to WIDTH-1, so the first grant matches fixed priority.
  - flush does not change ptr.
- **Not defined:** fixed highest-index priority; ptr and its logic are absent.
- Port list is identical in both builds.

## Structure
- Shared package prio_enc_pkg holds:
  - the index-width helper;
  - a popcount function;
  - the onehot(index) function.
- Sub-module prio_find:
  - combinational highest-set-bit finder over WIDTH bits;
  - outputs found and idx.
  - Instantiated once on P (fixed priority) or on the rotated vector (RR: rotate P by ptr, find, un-rotate the index).
- Top level holds all registers, the handshake, and flush/reset handling.

## Test plan
- **Reset:** with rst=1 for 2 cycles → out_valid=0, out_idx=0, pend_cnt=0.
- **Fixed priority, WIDTH=8:**
  - Stimulus: req=8'b1010_0100 for one cycle, out_ready=1.
  - Expected: out_idx issues 7, 5, 2 on consecutive cycles starting 2 cycles after req; pend_cnt goes 3,2,1,0; then out_valid=0.
- **Stall:**
  - Stimulus: req=8'b0001_0001, out_ready=0 for 5 cycles.
  - Expected: out_idx=4 held stable; pend_cnt=1; after out_ready=1, indices 4 then 0 issue.
- **Re-request during issue:**
  - Stimulus: bit 3 pending, req[3]=1 on the cycle 3 loads.
  - Expected: 3 issues twice.
- **flush:**
  - Stimulus: flush with P=8'hFF, out_valid=1, and req=8'h01 in the same cycle.
  - Expected: next cycle out_valid=0, pend_cnt=0; index 0 is never issued.
- **RR build (PRIO_ENC_QUEUE_RR_EN):**
  - Stimulus: req=8'hFF held every cycle, out_ready=1.
  - Expected: issue order 7,6,5,…,0,7,… with no index repeated within 8 grants.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// -----------------------------------------------------------------------------
// prio_enc_pkg
//
// Shared helpers for the queued priority encoder (prio_enc_queue) and its
// highest-set-bit finder (prio_find).
//
//   idx_width(w) : width of an index that can address w items (minimum 1)
//   popcount(v)  : number of set bits in v
//   onehot(idx)  : vector with only bit idx set
//
// popcount and onehot work on MAX_W-bit vectors. Callers zero-extend their
// operands to MAX_W bits, or truncate the result back to their own width,
// with a size cast.
// -----------------------------------------------------------------------------
package prio_enc_pkg;

    localparam int MAX_W = 64;

    function automatic int idx_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    function automatic int popcount(input logic [MAX_W-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_W; i++) begin
            cnt += int'(v[i]);
        end
        return cnt;
    endfunction

    function automatic logic [MAX_W-1:0] onehot(input int idx);
        return MAX_W'(1) << idx;
    endfunction

endpackage

// File: rtl/prio_find.sv
// -----------------------------------------------------------------------------
// prio_find
//
// Combinational highest-set-bit finder.
//
// Parameters:
//   WIDTH : number of bits searched
//   IDX_W : width of the index output
//
// Ports:
//   vec   : input  [WIDTH-1:0] vector to search
//   found : output             at least one bit of vec is set
//   idx   : output [IDX_W-1:0] index of the highest set bit (0 when none)
// -----------------------------------------------------------------------------
module prio_find
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Ascending scan: a later (higher) set bit overrides any earlier one,
    // so the last assignment is the highest set index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/prio_enc_queue.sv
// -----------------------------------------------------------------------------
// prio_enc_queue
//
// Registered priority encoder with request queueing. Each request bit is
// captured into a sticky pending register. Pending indices are issued one at
// a time to a single consumer over a valid/ready handshake. A pending bit is
// cleared when it is issued. If the same bit is re-requested in that cycle,
// it stays pending and is issued again later.
//
// Build option:
//   PRIO_ENC_QUEUE_RR_EN defined   : round-robin priority. The search starts
//                                    at ptr and descends, wrapping from 0 to
//                                    WIDTH-1. After each issue, ptr moves to
//                                    one below the issued index.
//   PRIO_ENC_QUEUE_RR_EN undefined : fixed priority; the highest index wins.
//   The port list is the same in both builds.
//
// Parameters:
//   WIDTH : number of request lines (>= 2)
//   IDX_W : width of out_idx (derived)
//   CNT_W : width of pend_cnt (derived)
//
// Ports:
//   clk       : input              clock; all state changes on the rising edge
//   rst       : input              synchronous active-high reset
//   req       : input  [WIDTH-1:0] request pulses/levels, ORed into pending
//   flush     : input              drop all pending requests and the held output
//   out_valid : output             out_idx holds an issued request
//   out_ready : input              consumer accepts out_idx when out_valid is high
//   out_idx   : output [IDX_W-1:0] index of the issued request
//   pend_cnt  : output [CNT_W-1:0] number of pending (not yet issued) requests
// -----------------------------------------------------------------------------
module prio_enc_queue
    import prio_enc_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = idx_width(WIDTH),
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [CNT_W-1:0] pend_cnt
);

    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] search_vec;
    logic             found;
    logic [IDX_W-1:0] find_idx;
    logic [IDX_W-1:0] sel;
    logic [WIDTH-1:0] sel_mask;
    logic             load;

    // The output register can take a new index when it is empty or is being
    // accepted this cycle. This lets back-to-back issues run with no bubble.
    assign load = !out_valid || out_ready;

    prio_find #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_find (
        .vec   (search_vec),
        .found (found),
        .idx   (find_idx)
    );

`ifdef PRIO_ENC_QUEUE_RR_EN
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W+1:0] unrot;

    // Rotate pend so that bit ptr lands on the top bit. The finder's normal
    // highest-first order then becomes "start at ptr, descend, wrap". With
    // the vector doubled, bit j of the shifted result is
    // pend[(j + ptr + 1) mod WIDTH].
    always_comb begin
        search_vec = WIDTH'({pend, pend} >> ((IDX_W+1)'(ptr) + (IDX_W+1)'(1)));

        // Map the finder index back to the original bit position.
        unrot = (IDX_W+2)'(find_idx) + (IDX_W+2)'(ptr) + (IDX_W+2)'(1);
        if (unrot >= (IDX_W+2)'(WIDTH)) begin
            unrot = unrot - (IDX_W+2)'(WIDTH);
        end
        sel = unrot[IDX_W-1:0];

        // The next search starts just below the winner. Wrapping below 0
        // gives WIDTH-1.
        ptr_next = (sel == '0) ? IDX_W'(WIDTH - 1) : sel - 1'b1;
    end

    // Starting at WIDTH-1 makes the first grant after reset match fixed
    // priority. flush leaves the rotation where it was.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IDX_W'(WIDTH - 1);
        end else if (!flush && load && found) begin
            ptr <= ptr_next;
        end
    end
`else
    always_comb begin
        search_vec = pend;
        sel        = find_idx;
    end
`endif

    assign sel_mask = WIDTH'(onehot(int'(sel)));

    // Pending register and output register. Requests are ORed in every cycle
    // unless flush is asserted. Clearing the issued bit comes before that OR,
    // so a same-cycle re-request of the winner keeps its bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else if (flush) begin
            pend      <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else if (load) begin
            if (found) begin
                pend      <= (pend & ~sel_mask) | req;
                out_valid <= 1'b1;
                out_idx   <= sel;
            end else begin
                pend      <= req;
                out_valid <= 1'b0;
            end
        end else begin
            pend <= pend | req;
        end
    end

    // An issued index has already left pend, so this count covers only the
    // requests that are still waiting.
    assign pend_cnt = CNT_W'(popcount(MAX_W'(pend)));

endmodule

// File: tb/tb_prio_enc_queue.sv
// -----------------------------------------------------------------------------
// tb_prio_enc_queue
//
// Directed test bench for prio_enc_queue with WIDTH=8. Each expected value
// is worked out by hand from the intended behaviour. Inputs change 1 time
// unit after a rising edge. Outputs are checked at the same point, so they
// show the state left by that edge.
// -----------------------------------------------------------------------------
module tb_prio_enc_queue;

    localparam int WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic [3:0] pend_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    prio_enc_queue #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .pend_cnt  (pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks one issued index: out_valid high, out_idx and pend_cnt as given.
    task automatic expect_issue(input string tag, input int unsigned idx, input int unsigned cnt);
        check({tag, " valid"}, out_valid, 1);
        check({tag, " idx"}, out_idx, idx);
        check({tag, " cnt"}, pend_cnt, cnt);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = 8'hFF;
        flush     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check("reset valid", out_valid, 0);
        check("reset idx", out_idx, 0);
        check("reset cnt", pend_cnt, 0);
        rst = 1'b0;
        req = 8'h00;
        step();
        check("post-reset cnt", pend_cnt, 0);
        check("post-reset valid", out_valid, 0);
    endtask

    initial begin
        do_reset();

        // flush with P=FF, output held, and req=01 in the same cycle
        out_ready = 1'b0;
        req       = 8'hFF;
        step();
        check("fl fill cnt", pend_cnt, 8);
        check("fl fill valid", out_valid, 0);
        step();
        expect_issue("fl held", 7, 8);
        flush = 1'b1;
        req   = 8'h01;
        step();
        flush     = 1'b0;
        req       = 8'h00;
        out_ready = 1'b1;
        check("fl valid", out_valid, 0);
        check("fl cnt", pend_cnt, 0);
        check("fl idx", out_idx, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl no issue", out_valid, 0);
            check("fl stays empty", pend_cnt, 0);
        end

`ifdef PRIO_ENC_QUEUE_RR_EN
        // Round-robin order with every line requesting continuously
        do_reset();
        out_ready = 1'b1;
        req       = 8'hFF;
        step();
        check("rr fill cnt", pend_cnt, 8);
        for (int i = 0; i < 16; i++) begin
            step();
            check("rr valid", out_valid, 1);
            check("rr idx", out_idx, 7 - (i % 8));
        end
        req = 8'h00;
`else
        // Fixed priority: 7, 5, 2 back to back
        out_ready = 1'b1;
        req       = 8'b1010_0100;
        step();
        req = 8'h00;
        check("fx capture cnt", pend_cnt, 3);
        check("fx capture valid", out_valid, 0);
        step();
        expect_issue("fx 1st", 7, 2);
        step();
        expect_issue("fx 2nd", 5, 1);
        step();
        expect_issue("fx 3rd", 2, 0);
        step();
        check("fx drained valid", out_valid, 0);

        // Stall: out_idx 4 stays stable while the consumer is not ready
        out_ready = 1'b0;
        req       = 8'b0001_0001;
        step();
        req = 8'h00;
        check("st capture cnt", pend_cnt, 2);
        step();
        expect_issue("st load", 4, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            expect_issue("st hold", 4, 1);
        end
        out_ready = 1'b1;
        step();
        expect_issue("st next", 0, 0);
        step();
        check("st drained valid", out_valid, 0);

        // Re-request of bit 3 on the cycle it is issued
        req = 8'h08;
        step();
        check("rq capture cnt", pend_cnt, 1);
        step();
        req = 8'h00;
        expect_issue("rq 1st", 3, 1);
        step();
        expect_issue("rq 2nd", 3, 0);
        step();
        check("rq drained valid", out_valid, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
